motor_mixer: RTL and testbench
==============================

Name: motor_mixer

Overview:
- Downstream consumer of the three per-axis pid rate controllers (roll, pitch, yaw).
- Combines their signed rate_out values with the pilot throttle into four unsigned motor commands for an X-configuration quad.
- Commands feed the PWM generator stage.
- Runs one start/complete handshake per control tick, using the same style as the pid blocks.

Parameters:
- RATE_SHIFT, 4: arithmetic right shift applied to each axis rate before mixing.
- MOTOR_MIN, 8'd0: lower clamp for motor commands.
- MOTOR_MAX, 8'd250: upper clamp for motor commands.
- THROTTLE_CUTOFF, 8'd10: throttle strictly below this value forces all motors to 0.
- SLEW_STEP, 8'd8: maximum per-update change of any motor command (only used with MOTOR_MIXER_SLEW_EN).

Ports:
- us_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- roll_rate  in  16 signed  roll pid rate_out (`PID_RATE_BIT_WIDTH).
- pitch_rate  in  16 signed  pitch pid rate_out.
- yaw_rate  in  16 signed  yaw pid rate_out.
- throttle  in  8 unsigned  collective throttle.
- start_flag  in  1  begin one mix; sampled in IDLE.
- wait_flag  in  1  return from COMPLETE to IDLE.
- motor_1_rate .. motor_4_rate  out  8 each  registered motor commands.
- mixer_active  out  1  high in LATCH through COMPLETE.
- mixer_complete  out  1  high only in COMPLETE.

Behaviour:
- Reset: all motor outputs 0, mixer_active=0, mixer_complete=0, state=IDLE, internal regs 0. Reset asserted mid-operation aborts immediately to these values.
- States are one-hot: IDLE, LATCH, SUM, CLAMP, [SLEW], COMPLETE.
- IDLE: start_flag=1 -> LATCH, else stay. Motor outputs hold their last values.
- LATCH: capture all four inputs into internal registers -> SUM. Input changes after LATCH are ignored.
- SUM: R,P,Y = rate >>> RATE_SHIFT (sign-preserving floor). T = throttle zero-extended. All math is 18-bit signed; no overflow is possible.
  - m1 = T+R+P−Y (front-left)
  - m2 = T−R+P+Y (front-right)
  - m3 = T−R−P−Y (rear-right)
  - m4 = T+R−P+Y (rear-left)
  - -> CLAMP.
- CLAMP:
  - If latched throttle < THROTTLE_CUTOFF, every motor is 0; this overrides MOTOR_MIN.
  - Otherwise each mN is clamped to [MOTOR_MIN, MOTOR_MAX].
  - The result is written to the motor outputs -> COMPLETE (or SLEW when enabled).
- COMPLETE: mixer_complete=1. wait_flag=1 -> IDLE, else hold.
- Latency: start_flag sampled at edge N. Outputs and mixer_complete are valid after edge N+3 (N+4 with slew).
- start_flag outside IDLE is ignored.
- start_flag and wait_flag together in COMPLETE: wait_flag wins, go to IDLE. A new start is then taken on the next edge if still high.

Optional Feature:
- Macro: MOTOR_MIXER_SLEW_EN.
- Defined:
  - CLAMP writes internal targets instead of the outputs.
  - An extra SLEW state moves each output toward its target by at most SLEW_STEP, reaching the target exactly if closer than that.
  - Cutoff (throttle < THROTTLE_CUTOFF) bypasses slew and forces outputs to 0 at once.
- Undefined: no SLEW state; clamped values go straight to the outputs; SLEW_STEP is unused.

Decomposition:
- Shared package/defines file holds:
  - `PID_RATE_BIT_WIDTH (16)
  - motor command width (8)
  - mixer state encodings
  - default MOTOR_MIN/MOTOR_MAX
- Natural sub-module: motor_clamp. It is combinational: 18-bit signed in, cutoff flag, min/max, 8-bit out. It is instantiated four times; the FSM stays in motor_mixer.

Test Plan:
- Basic mix: T=100, roll=160, pitch=0, yaw=0, start pulse -> complete after 3 edges; m1=110, m2=90, m3=90, m4=110.
- Upper clamp: T=240, pitch=800 -> m1=250, m2=250, m3=190, m4=190.
- Negative rate and floor shift:
  - T=20, roll=−800 -> m1=0, m2=70, m3=70, m4=0.
  - T=100, yaw=−15 -> Y=−1; m1=101, m2=99, m3=101, m4=99.
- Cutoff: T=5, roll=1600 -> all motors 0.
  - Same check with wait_flag and start_flag asserted together in COMPLETE -> IDLE, then restart, outputs still 0.
- Reset mid-op: assert reset in SUM -> outputs 0 and mixer_active=0 immediately. Release, start T=100 with all rates 0 -> all motors 100.
- Slew (MOTOR_MIXER_SLEW_EN): from all 0, T=100 with all rates 0 -> outputs 8, then 16, 24 on successive mixes.
  - Same bench without the macro -> 100 after the first mix, latency 3.

Source files
------------

// File: rtl/motor_mixer_pkg.sv
// Shared widths, state encodings and default command limits for the motor mixer.
// Optional output slew limiting is enabled with the MOTOR_MIXER_SLEW_EN macro.
`ifndef PID_RATE_BIT_WIDTH
`define PID_RATE_BIT_WIDTH 16
`endif

package motor_mixer_pkg;

  localparam int PID_RATE_W = `PID_RATE_BIT_WIDTH;
  localparam int MOTOR_W    = 8;
  localparam int SUM_W      = 18;

  localparam logic [MOTOR_W-1:0] MOTOR_MIN_DEF = 8'd0;
  localparam logic [MOTOR_W-1:0] MOTOR_MAX_DEF = 8'd250;

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_LATCH    = 6'b000010,
    ST_SUM      = 6'b000100,
    ST_CLAMP    = 6'b001000,
    ST_SLEW     = 6'b010000,
    ST_COMPLETE = 6'b100000
  } mixer_state_t;

  function automatic logic signed [SUM_W-1:0] zext_cmd(input logic [MOTOR_W-1:0] v);
    return $signed({{(SUM_W-MOTOR_W){1'b0}}, v});
  endfunction

endpackage

// File: rtl/motor_clamp.sv
// Combinational limiter: one 18-bit signed mix term to an 8-bit motor command.
// The throttle cutoff forces zero and takes priority over the lower limit.
module motor_clamp
  import motor_mixer_pkg::*;
(
  input  logic signed [SUM_W-1:0]   mix,
  input  logic                      cutoff,
  input  logic        [MOTOR_W-1:0] min_cmd,
  input  logic        [MOTOR_W-1:0] max_cmd,
  output logic        [MOTOR_W-1:0] cmd
);

  function automatic logic [MOTOR_W-1:0] saturate(
    input logic signed [SUM_W-1:0]   v,
    input logic        [MOTOR_W-1:0] lo,
    input logic        [MOTOR_W-1:0] hi
  );
    if (v < zext_cmd(lo))
      return lo;
    else if (v > zext_cmd(hi))
      return hi;
    else
      return v[MOTOR_W-1:0];
  endfunction

  assign cmd = cutoff ? '0 : saturate(mix, min_cmd, max_cmd);

endmodule

// File: rtl/motor_mixer.sv
// X-quad mixer: throttle plus roll/pitch/yaw rates into four motor commands,
// one start/complete handshake per control tick. Macro MOTOR_MIXER_SLEW_EN adds slew limiting.
module motor_mixer
  import motor_mixer_pkg::*;
#(
  parameter int                 RATE_SHIFT      = 4,
  parameter logic [MOTOR_W-1:0] MOTOR_MIN       = MOTOR_MIN_DEF,
  parameter logic [MOTOR_W-1:0] MOTOR_MAX       = MOTOR_MAX_DEF,
  parameter logic [MOTOR_W-1:0] THROTTLE_CUTOFF = 8'd10,
  parameter logic [MOTOR_W-1:0] SLEW_STEP       = 8'd8
) (
  input  logic                                 us_clk,
  input  logic                                 reset,
  input  logic signed [`PID_RATE_BIT_WIDTH-1:0] roll_rate,
  input  logic signed [`PID_RATE_BIT_WIDTH-1:0] pitch_rate,
  input  logic signed [`PID_RATE_BIT_WIDTH-1:0] yaw_rate,
  input  logic        [MOTOR_W-1:0]             throttle,
  input  logic                                 start_flag,
  input  logic                                 wait_flag,
  output logic        [MOTOR_W-1:0]             motor_1_rate,
  output logic        [MOTOR_W-1:0]             motor_2_rate,
  output logic        [MOTOR_W-1:0]             motor_3_rate,
  output logic        [MOTOR_W-1:0]             motor_4_rate,
  output logic                                 mixer_active,
  output logic                                 mixer_complete
);

  if (MOTOR_MIN > MOTOR_MAX || SLEW_STEP == '0) begin : g_bad_params
    $error("motor_mixer: MOTOR_MIN above MOTOR_MAX or zero SLEW_STEP");
  end

  mixer_state_t state;

  logic signed [PID_RATE_W-1:0] roll_p0, pitch_p0, yaw_p0;
  logic        [MOTOR_W-1:0]    thr_p0;
  logic signed [SUM_W-1:0]      mix_p1 [4];
  logic        [MOTOR_W-1:0]    clamp_cmd [4];
  logic        [MOTOR_W-1:0]    motor_q [4];
`ifdef MOTOR_MIXER_SLEW_EN
  logic        [MOTOR_W-1:0]    tgt_p2 [4];
`endif

  logic signed [SUM_W-1:0] r_term, p_term, y_term, t_term;
  logic                    cutoff;

  function automatic logic signed [SUM_W-1:0] scale_rate(input logic signed [PID_RATE_W-1:0] r);
    logic signed [SUM_W-1:0] ext;
    ext = {{(SUM_W-PID_RATE_W){r[PID_RATE_W-1]}}, r};
    return ext >>> RATE_SHIFT;
  endfunction

`ifdef MOTOR_MIXER_SLEW_EN
  function automatic logic [MOTOR_W-1:0] slew_toward(
    input logic [MOTOR_W-1:0] cur,
    input logic [MOTOR_W-1:0] tgt
  );
    if (tgt > cur)
      return (tgt - cur > SLEW_STEP) ? cur + SLEW_STEP : tgt;
    else
      return (cur - tgt > SLEW_STEP) ? cur - SLEW_STEP : tgt;
  endfunction
`endif

  assign r_term = scale_rate(roll_p0);
  assign p_term = scale_rate(pitch_p0);
  assign y_term = scale_rate(yaw_p0);
  assign t_term = zext_cmd(thr_p0);
  assign cutoff = thr_p0 < THROTTLE_CUTOFF;

  for (genvar i = 0; i < 4; i++) begin : g_clamp
    motor_clamp u_clamp (
      .mix     (mix_p1[i]),
      .cutoff  (cutoff),
      .min_cmd (MOTOR_MIN),
      .max_cmd (MOTOR_MAX),
      .cmd     (clamp_cmd[i])
    );
  end

  assign motor_1_rate = motor_q[0];
  assign motor_2_rate = motor_q[1];
  assign motor_3_rate = motor_q[2];
  assign motor_4_rate = motor_q[3];

  always_ff @(posedge us_clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      mixer_active   <= 1'b0;
      mixer_complete <= 1'b0;
      roll_p0        <= '0;
      pitch_p0       <= '0;
      yaw_p0         <= '0;
      thr_p0         <= '0;
      for (int i = 0; i < 4; i++) begin
        mix_p1[i]  <= '0;
        motor_q[i] <= '0;
`ifdef MOTOR_MIXER_SLEW_EN
        tgt_p2[i]  <= '0;
`endif
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_flag) begin
            state        <= ST_LATCH;
            mixer_active <= 1'b1;
          end
        end
        // p0: input capture; later input changes do not affect this mix
        ST_LATCH: begin
          roll_p0  <= roll_rate;
          pitch_p0 <= pitch_rate;
          yaw_p0   <= yaw_rate;
          thr_p0   <= throttle;
          state    <= ST_SUM;
        end
        // p1: X-quad mix, motors numbered FL, FR, RR, RL
        ST_SUM: begin
          mix_p1[0] <= t_term + r_term + p_term - y_term;
          mix_p1[1] <= t_term - r_term + p_term + y_term;
          mix_p1[2] <= t_term - r_term - p_term - y_term;
          mix_p1[3] <= t_term + r_term - p_term + y_term;
          state     <= ST_CLAMP;
        end
        // p2: limited commands reach the outputs (or the slew targets)
        ST_CLAMP: begin
`ifdef MOTOR_MIXER_SLEW_EN
          for (int i = 0; i < 4; i++) begin
            tgt_p2[i] <= clamp_cmd[i];
            if (cutoff)
              motor_q[i] <= '0;
          end
          state <= ST_SLEW;
`else
          for (int i = 0; i < 4; i++)
            motor_q[i] <= clamp_cmd[i];
          state          <= ST_COMPLETE;
          mixer_complete <= 1'b1;
`endif
        end
`ifdef MOTOR_MIXER_SLEW_EN
        ST_SLEW: begin
          for (int i = 0; i < 4; i++)
            motor_q[i] <= slew_toward(motor_q[i], tgt_p2[i]);
          state          <= ST_COMPLETE;
          mixer_complete <= 1'b1;
        end
`endif
        ST_COMPLETE: begin
          if (wait_flag) begin
            state          <= ST_IDLE;
            mixer_active   <= 1'b0;
            mixer_complete <= 1'b0;
          end
        end
        default: begin
          state          <= ST_IDLE;
          mixer_active   <= 1'b0;
          mixer_complete <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_mixer.sv
// Directed bench for motor_mixer with an arithmetic reference model and per-cycle compare.
// Build with MOTOR_MIXER_SLEW_EN to exercise the slew-limited variant.
`timescale 1ns/1ps
module tb_motor_mixer;

`ifdef MOTOR_MIXER_SLEW_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic               us_clk = 1'b0;
  logic               reset;
  logic signed [15:0] roll_rate, pitch_rate, yaw_rate;
  logic        [7:0]  throttle;
  logic               start_flag, wait_flag;
  logic        [7:0]  motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate;
  logic               mixer_active, mixer_complete;
  logic        [7:0]  dut_m [4];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;
  bit exp_active, exp_complete;
  int exp_m [4];
  int mdl_tgt [4];
  bit mdl_cut;

  motor_mixer dut (
    .us_clk         (us_clk),
    .reset          (reset),
    .roll_rate      (roll_rate),
    .pitch_rate     (pitch_rate),
    .yaw_rate       (yaw_rate),
    .throttle       (throttle),
    .start_flag     (start_flag),
    .wait_flag      (wait_flag),
    .motor_1_rate   (motor_1_rate),
    .motor_2_rate   (motor_2_rate),
    .motor_3_rate   (motor_3_rate),
    .motor_4_rate   (motor_4_rate),
    .mixer_active   (mixer_active),
    .mixer_complete (mixer_complete)
  );

  always #5 us_clk = ~us_clk;

  always_comb begin
    dut_m[0] = motor_1_rate;
    dut_m[1] = motor_2_rate;
    dut_m[2] = motor_3_rate;
    dut_m[3] = motor_4_rate;
  end

  task automatic check(input string name, input integer act, input integer req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // floor(r / 16) written as integer division, not as a shift
  function automatic int rate_term(input int r);
    if (r >= 0) return r / 16;
    return -((-r + 15) / 16);
  endfunction

  function automatic int step_toward(input int cur, input int tgt);
    if (tgt > cur) return (tgt - cur > 8) ? cur + 8 : tgt;
    return (cur - tgt > 8) ? cur - 8 : tgt;
  endfunction

  task automatic set_inputs(input int t, input int r, input int p, input int y);
    int rr, pp, yy;
    int m [4];
    throttle   = 8'(t);
    roll_rate  = 16'(r);
    pitch_rate = 16'(p);
    yaw_rate   = 16'(y);
    rr = rate_term(r);
    pp = rate_term(p);
    yy = rate_term(y);
    m[0] = t + rr + pp - yy;
    m[1] = t - rr + pp + yy;
    m[2] = t - rr - pp - yy;
    m[3] = t + rr - pp + yy;
    mdl_cut = (t < 10);
    for (int i = 0; i < 4; i++)
      mdl_tgt[i] = mdl_cut ? 0 : (m[i] < 0 ? 0 : (m[i] > 250 ? 250 : m[i]));
  endtask

  task automatic apply_model();
    for (int i = 0; i < 4; i++) begin
`ifdef MOTOR_MIXER_SLEW_EN
      exp_m[i] = mdl_cut ? 0 : step_toward(exp_m[i], mdl_tgt[i]);
`else
      exp_m[i] = mdl_tgt[i];
`endif
    end
  endtask

  // start_flag is already high; returns at a negedge while COMPLETE is held
  task automatic run_mix();
    @(posedge us_clk);
    exp_active = 1'b1;
    @(negedge us_clk);
    start_flag = 1'b0;
    @(posedge us_clk);
    @(negedge us_clk);
    throttle   = 8'($urandom);
    roll_rate  = 16'($urandom);
    pitch_rate = 16'($urandom);
    yaw_rate   = 16'($urandom);
    for (int k = 2; k <= LAT; k++) begin
      @(posedge us_clk);
      if (k == LAT) begin
        apply_model();
        exp_complete = 1'b1;
      end
    end
    @(negedge us_clk);
    start_flag = 1'b1;
    @(negedge us_clk);
    start_flag = 1'b0;
  endtask

  task automatic launch(input int t, input int r, input int p, input int y);
    @(negedge us_clk);
    set_inputs(t, r, p, y);
    start_flag = 1'b1;
    run_mix();
  endtask

  task automatic release_mix();
    @(negedge us_clk);
    wait_flag = 1'b1;
    @(posedge us_clk);
    exp_active   = 1'b0;
    exp_complete = 1'b0;
    @(negedge us_clk);
    wait_flag = 1'b0;
  endtask

  task automatic expect_motors(input string tag, input int a, input int b, input int c, input int d);
    check({tag, "_m1"}, dut_m[0], a);
    check({tag, "_m2"}, dut_m[1], b);
    check({tag, "_m3"}, dut_m[2], c);
    check({tag, "_m4"}, dut_m[3], d);
  endtask

  always @(negedge us_clk) begin
    if (chk_en) begin
      check("active", mixer_active, exp_active);
      check("complete", mixer_complete, exp_complete);
      if (!exp_active || exp_complete)
        for (int i = 0; i < 4; i++)
          check($sformatf("motor%0d", i + 1), dut_m[i], exp_m[i]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    start_flag = 1'b0;
    wait_flag  = 1'b0;
    set_inputs(0, 0, 0, 0);
    exp_active   = 1'b0;
    exp_complete = 1'b0;
    for (int i = 0; i < 4; i++) exp_m[i] = 0;
    repeat (2) @(negedge us_clk);
    expect_motors("reset", 0, 0, 0, 0);
    check("reset_active", mixer_active, 0);
    check("reset_complete", mixer_complete, 0);
    reset = 1'b0;
    @(posedge us_clk);
    chk_en = 1'b1;

    // three identical mixes from zero: direct build jumps, slew build ramps
    launch(100, 0, 0, 0);
`ifdef MOTOR_MIXER_SLEW_EN
    expect_motors("slew1", 8, 8, 8, 8);
`else
    expect_motors("flat1", 100, 100, 100, 100);
`endif
    release_mix();
    launch(100, 0, 0, 0);
`ifdef MOTOR_MIXER_SLEW_EN
    expect_motors("slew2", 16, 16, 16, 16);
`else
    expect_motors("flat2", 100, 100, 100, 100);
`endif
    release_mix();
    launch(100, 0, 0, 0);
`ifdef MOTOR_MIXER_SLEW_EN
    expect_motors("slew3", 24, 24, 24, 24);
`else
    expect_motors("flat3", 100, 100, 100, 100);
`endif
    release_mix();

    launch(100, 160, 0, 0);
`ifndef MOTOR_MIXER_SLEW_EN
    expect_motors("basic", 110, 90, 90, 110);
`endif
    release_mix();

    launch(240, 0, 800, 0);
`ifndef MOTOR_MIXER_SLEW_EN
    expect_motors("upper", 250, 250, 190, 190);
`endif
    release_mix();

    launch(20, -800, 0, 0);
`ifndef MOTOR_MIXER_SLEW_EN
    expect_motors("negroll", 0, 70, 70, 0);
`endif
    release_mix();

    launch(100, 0, 0, -15);
`ifndef MOTOR_MIXER_SLEW_EN
    expect_motors("yawfloor", 101, 99, 101, 99);
`endif
    release_mix();

    // asynchronous reset while in SUM
    @(negedge us_clk);
    set_inputs(100, 160, 0, 0);
    start_flag = 1'b1;
    @(posedge us_clk);
    exp_active = 1'b1;
    @(negedge us_clk);
    start_flag = 1'b0;
    @(posedge us_clk);
    @(negedge us_clk);
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    expect_motors("midreset", 0, 0, 0, 0);
    check("midreset_active", mixer_active, 0);
    check("midreset_complete", mixer_complete, 0);
    exp_active   = 1'b0;
    exp_complete = 1'b0;
    for (int i = 0; i < 4; i++) exp_m[i] = 0;
    @(negedge us_clk);
    reset = 1'b0;
    @(posedge us_clk);
    chk_en = 1'b1;

    launch(100, 0, 0, 0);
`ifdef MOTOR_MIXER_SLEW_EN
    expect_motors("postreset", 8, 8, 8, 8);
`else
    expect_motors("postreset", 100, 100, 100, 100);
`endif
    release_mix();

    launch(5, 1600, 0, 0);
    expect_motors("cutoff", 0, 0, 0, 0);

    // wait_flag and start_flag together: back to IDLE, then restart
    @(negedge us_clk);
    set_inputs(5, 1600, 0, 0);
    wait_flag  = 1'b1;
    start_flag = 1'b1;
    @(posedge us_clk);
    exp_active   = 1'b0;
    exp_complete = 1'b0;
    @(negedge us_clk);
    wait_flag = 1'b0;
    check("restart_idle", mixer_active, 0);
    run_mix();
    expect_motors("cutoff2", 0, 0, 0, 0);
    release_mix();

    repeat (2) @(negedge us_clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
